// File: rtl/bcd_to_led7seg_anode_decoder.sv
// rtl/bcd_to_led7seg_anode_decoder.sv - registered BCD/hex to common-anode 7-segment decoder
// Active-low segment drive with dp, blank, lamp test, invalid-code flag and PWM dimming.
module bcd_to_led7seg_anode_decoder #(
  parameter bit HEX_EN   = 1'b1,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          w,
  input  logic                dp,
  input  logic                blank,
  input  logic                lamp_test,
  input  logic [PWM_BITS-1:0] bright,
  output logic [7:0]          y,
  output logic                err
);

  logic [PWM_BITS-1:0] cnt;
  logic [6:0]          seg;
  logic                pwm_en;
  logic [7:0]          y_next;

  // Segment patterns g..a, active low.
  always_comb begin
    seg = 7'h7F;
    case (w)
      4'd0:  seg = 7'h40;
      4'd1:  seg = 7'h79;
      4'd2:  seg = 7'h24;
      4'd3:  seg = 7'h30;
      4'd4:  seg = 7'h19;
      4'd5:  seg = 7'h12;
      4'd6:  seg = 7'h02;
      4'd7:  seg = 7'h78;
      4'd8:  seg = 7'h00;
      4'd9:  seg = 7'h10;
      4'd10: seg = HEX_EN ? 7'h08 : 7'h7F;
      4'd11: seg = HEX_EN ? 7'h03 : 7'h7F;
      4'd12: seg = HEX_EN ? 7'h46 : 7'h7F;
      4'd13: seg = HEX_EN ? 7'h21 : 7'h7F;
      4'd14: seg = HEX_EN ? 7'h06 : 7'h7F;
      4'd15: seg = HEX_EN ? 7'h0E : 7'h7F;
      default: seg = 7'h7F;
    endcase
  end

  assign pwm_en = (bright == {PWM_BITS{1'b1}}) || (cnt < bright);

  always_comb begin
    y_next = 8'hFF;
    if (lamp_test)
      y_next = 8'h00;
    else if (blank)
      y_next = 8'hFF;
    else if (pwm_en)
      y_next = {~dp, seg};
  end

  // Lamp test overrides everything, including the PWM gate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      y   <= 8'hFF;
      err <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      y   <= y_next;
      err <= (w > 4'd9);
    end
  end

endmodule

// File: tb/tb_bcd_to_led7seg_anode_decoder.sv
// tb/tb_bcd_to_led7seg_anode_decoder.sv - scoreboard bench for the 7-segment decoder
module tb_bcd_to_led7seg_anode_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] w = '0;
  logic       dp = 1'b0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [3:0] bright = '0;
  logic [7:0] y_hex, y_nohex;
  logic       err_hex, err_nohex;

  int checks = 0;
  int errors = 0;
  int lit_count = 0;
  logic [3:0] cnt_m;

  typedef struct {
    logic [7:0] y;
    logic [7:0] y_nh;
    logic       err;
    bit         tag;
  } exp_t;
  exp_t q[$];

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  bcd_to_led7seg_anode_decoder #(.HEX_EN(1'b1), .PWM_BITS(4)) dut_hex (
    .clk(clk), .rst(rst), .w(w), .dp(dp), .blank(blank), .lamp_test(lamp_test),
    .bright(bright), .y(y_hex), .err(err_hex)
  );

  bcd_to_led7seg_anode_decoder #(.HEX_EN(1'b0), .PWM_BITS(4)) dut_nohex (
    .clk(clk), .rst(rst), .w(w), .dp(dp), .blank(blank), .lamp_test(lamp_test),
    .bright(bright), .y(y_nohex), .err(err_nohex)
  );

  always #5 clk = ~clk;

  // Cycle count since reset, i.e. the PWM phase the next edge will use.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt_m <= '0;
    else     cnt_m <= cnt_m + 4'd1;
  end

  function automatic logic [7:0] model_y(input logic [3:0] wv, input logic dpv, input logic bl,
                                         input logic lt, input logic [3:0] br, input logic [3:0] c,
                                         input bit hex);
    logic [7:0] s;
    if (lt) return 8'h00;
    if (bl) return 8'hFF;
    if (!(br == 4'hF || c < br)) return 8'hFF;
    s = (!hex && wv > 4'd9) ? 8'hFF : seg_tbl[wv];
    return dpv ? (s & 8'h7F) : s;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, req);
    end
  endtask

  task automatic step(input logic [3:0] wv, input logic dpv, input logic bl, input logic lt,
                      input logic [3:0] br, input bit tag);
    exp_t e;
    @(negedge clk);
    w = wv; dp = dpv; blank = bl; lamp_test = lt; bright = br;
    e.y    = model_y(wv, dpv, bl, lt, br, cnt_m, 1'b1);
    e.y_nh = model_y(wv, dpv, bl, lt, br, cnt_m, 1'b0);
    e.err  = (wv > 4'd9);
    e.tag  = tag;
    q.push_back(e);
  endtask

  // Monitor: the decoder presents a fresh output after every edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("y_hex", y_hex, e.y);
      check("y_nohex", y_nohex, e.y_nh);
      check("err_hex", {7'd0, err_hex}, {7'd0, e.err});
      check("err_nohex", {7'd0, err_nohex}, {7'd0, e.err});
      if (e.tag && y_hex === 8'hF9) lit_count++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_y", y_hex, 8'hFF);
    check("reset_err", {7'd0, err_hex}, 8'h00);
    @(negedge clk);
    check("reset_y_held", y_hex, 8'hFF);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) step(4'(i), 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);

    step(4'd12, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    step(4'd9,  1'b0, 1'b0, 1'b0, 4'hF, 1'b0);

    step(4'd8, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0);
    step(4'd8, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
    step(4'd8, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0);
    step(4'd3, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
    step(4'd3, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    step(4'd13, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0);

    for (int i = 0; i < 16; i++) step(4'd1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1);
    for (int i = 0; i < 16; i++) step(4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) step(4'd1, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0);

    step(4'd14, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    step(4'd5, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    step(4'd5, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_y", y_hex, 8'hFF);
    check("async_rst_err", {7'd0, err_hex}, 8'h00);
    rst = 1'b0;
    step(4'd5, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    step(4'd2, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("pwm_lit_cycles", 8'(lit_count), 8'd4);
    check("queue_drained", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
